dmem_responder: RTL and testbench
=================================

# dmem_responder

Handshaked data-memory responder: the slave end of the pipeline's MEM-stage load/store port. Accepts one byte/half/word load or store per transaction, models a configurable fixed access latency, applies RISC-V funct3 size and sign rules, flags misaligned or illegal accesses, and returns a response under valid/ready flow control. It replaces the single-cycle data memory when the core is run against multi-cycle memory timing.

## Interface
- DATA_W, 32, data width; only 32 is supported
- DM_ADDRESS, 9, byte-address width
- MEM_WORDS, 128, 32-bit words of storage; must equal 2**(DM_ADDRESS-2)
- LAT, 2, access latency in cycles, legal range 1..7
- CNT_W, 16, statistics counter width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data; low bytes used for SB/SH
- req_funct3  in  3  access size/sign code
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  access was misaligned or illegal
- busy  out  1  state is not IDLE
- rd_count, wr_count, err_count  out  CNT_W each  saturating counts of completed loads, stores and errored accesses

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: capture we/addr/wdata/funct3, load the latency counter with LAT-1, go to ACCESS. Input changes after capture are ignored.
- ACCESS: req_ready=0. Decrement the counter each cycle. When it is 0, perform the access, register rsp_rdata/rsp_err, and go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid and rsp_ready are both high. On that handshake, go to IDLE.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Little-endian. The byte is selected by addr[1:0] and the half by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are written; other bytes of the word are unchanged.
- Errors:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 of 011 or any 1xx.
  - On error: no memory write, rsp_rdata=0, rsp_err=1, err_count increments. rd_count/wr_count do not increment.
- Counters increment once per completed access, when the response is registered. They saturate at all-ones.
- Storage array is not reset; its contents are undefined until written.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, all counters 0, state IDLE.
- Request accepted at edge E implies rsp_valid rises at edge E+LAT. A store's memory update is visible to any load accepted after E+LAT.
- With rsp_ready tied high: the handshake completes in the first RESP cycle, IDLE is entered at E+LAT+1, and the next accept is no earlier than E+LAT+1. Peak throughput is one access per LAT+1 cycles.
- rsp_ready low holds RESP indefinitely with outputs frozen; busy=1 and req_ready=0 throughout.
- req_ready is high only in IDLE. There is no same-cycle response-retire plus request-accept.
- Reset asserted mid-transaction, in ACCESS or RESP:
  - Return to IDLE immediately, with outputs at reset values.
  - A store not yet performed is discarded.
  - A store already performed in an earlier cycle remains in memory.

## Test plan
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 with LAT=2 -> rsp_valid exactly 2 cycles after each accept; rdata 0xDEADBEEF; wr_count=1, rd_count=1.
- After the above: LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x010 -> 0xFFFFBEEF; LHU 0x012 -> 0x0000DEAD.
- SB 0x011 data 0x00000055, then LW 0x010 -> 0xDEAD55EF; SH 0x012 data 0x1234 -> LW gives 0x123455EF.
- LW 0x012, SH 0x011 and load funct3=011 -> rsp_err=1, rdata 0, memory unchanged (LW 0x010 still 0x123455EF), err_count=3.
- Hold rsp_ready=0 for 5 cycles on a load -> rsp_valid/rdata stable, req_ready=0, a concurrent req_valid is not accepted; raise rsp_ready -> IDLE next cycle.
- Assert reset during ACCESS of SW 0x020 data 0xA5A5A5A5 -> all outputs at reset values asynchronously; after release, a write-then-read sequence completes normally with counters restarted from 0.

Source files
------------

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the MEM stage (master) and the data
// memory responder (slave).
interface dmem_if #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [2:0]            req_funct3;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory slave: one byte/half/word RISC-V load or store per
// transaction, fixed access latency, alignment checking, saturating statistics.
module dmem_responder #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int MEM_WORDS  = 128,
   parameter int LAT        = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   dmem_if.slave            bus,
   output logic             busy,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] err_count
);
   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state;
   logic [2:0]            lat_cnt;
   logic                  we_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [2:0]            f3_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic                  busy_q;

   logic [DATA_W-1:0]     mem [MEM_WORDS];

   logic [DM_ADDRESS-3:0] word_idx;
   logic [DATA_W-1:0]     rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_W-1:0]     load_data;
   logic                  access_err;
   logic [NB-1:0]         be;
   logic [DATA_W-1:0]     lane_data;
   logic                  do_access;
   logic                  mem_we;

   assign word_idx  = addr_q[DM_ADDRESS-1:2];
   assign rd_word   = mem[word_idx];
   assign do_access = (state == ACCESS) && (lat_cnt == 3'd0);
   assign mem_we    = do_access && we_q && !access_err;

   // Size/alignment legality of the captured request, separately for loads and stores
   always_comb begin
      access_err = 1'b0;
      if (we_q) begin
         case (f3_q)
            3'b000:  access_err = 1'b0;
            3'b001:  access_err = addr_q[0];
            3'b010:  access_err = |addr_q[1:0];
            default: access_err = 1'b1;
         endcase
      end else begin
         case (f3_q)
            3'b000, 3'b100: access_err = 1'b0;
            3'b001, 3'b101: access_err = addr_q[0];
            3'b010:         access_err = |addr_q[1:0];
            default:        access_err = 1'b1;
         endcase
      end
   end

   always_comb begin
      rd_byte = rd_word[7:0];
      case (addr_q[1:0])
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         2'd3: rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      load_data = '0;
      case (f3_q[1:0])
         2'b00: load_data = f3_q[2] ? {{(DATA_W-8){1'b0}}, rd_byte}
                                    : {{(DATA_W-8){rd_byte[7]}}, rd_byte};
         2'b01: load_data = f3_q[2] ? {{(DATA_W-16){1'b0}}, rd_half}
                                    : {{(DATA_W-16){rd_half[15]}}, rd_half};
         2'b10: load_data = rd_word;
         default: load_data = '0;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes
   always_comb begin
      be        = '0;
      lane_data = wdata_q;
      case (f3_q)
         3'b000: begin
            be        = NB'(1) << addr_q[1:0];
            lane_data = {NB{wdata_q[7:0]}};
         end
         3'b001: begin
            be        = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {(NB/2){wdata_q[15:0]}};
         end
         3'b010: begin
            be        = '1;
            lane_data = wdata_q;
         end
         default: be = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         f3_q        <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
         rd_count    <= '0;
         wr_count    <= '0;
         err_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q        <= bus.req_we;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  f3_q        <= bus.req_funct3;
                  lat_cnt     <= 3'(LAT - 1);
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (lat_cnt == 3'd0) begin
                  rsp_rdata_q <= (we_q || access_err) ? '0 : load_data;
                  rsp_err_q   <= access_err;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
                  if (access_err) begin
                     if (err_count != '1) err_count <= err_count + 1'b1;
                  end else if (we_q) begin
                     if (wr_count != '1) wr_count <= wr_count + 1'b1;
                  end else begin
                     if (rd_count != '1) rd_count <= rd_count + 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a negedge monitor checks latency, data and error flag of every response.
module tb_dmem_responder;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic [15:0] rd_count, wr_count, err_count;

   dmem_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

   dmem_responder #(.LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .busy      (busy),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t sb[$];
   logic prev_valid = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every cycle a response is shown it must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         prev_valid = 1'b0;
      end else if (bus.rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rdata %h with no request outstanding", bus.rsp_rdata);
         end else begin
            if (!prev_valid) check_output("latency", 32'(cyc - sb[0].acc), 32'(LAT));
            check_output("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
            check_output("rsp_err", {31'b0, bus.rsp_err}, {31'b0, sb[0].err});
            if (bus.rsp_ready) void'(sb.pop_front());
         end
         prev_valid = 1'b1;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic apply_stimulus(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      int   n;
      @(negedge clk);
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      bus.req_valid  = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got req_ready 0 expected 1 at addr %h", addr);
         bus.req_valid = 1'b0;
         return;
      end
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.acc   = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      @(negedge clk);
      while (!(sb.size() == 0 && bus.req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d responses pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
      apply_stimulus(we, addr, wdata, f3, exp_rdata, exp_err);
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = '0;
      bus.rsp_ready  = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check_output("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check_output("reset_busy", {31'b0, busy}, 32'd0);
      check_output("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_output("reset_counts", {rd_count, wr_count | err_count}, 32'd0);
      reset = 1'b1;

      // Word write/read, then sub-word extraction with sign and zero extension
      run(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
      run(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
      check_output("wr_count_1", 32'(wr_count), 32'd1);
      check_output("rd_count_1", 32'(rd_count), 32'd1);
      run(1'b0, 9'h013, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0);
      run(1'b0, 9'h013, 32'h0, 3'b100, 32'h000000DE, 1'b0);
      run(1'b0, 9'h010, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0);
      run(1'b0, 9'h012, 32'h0, 3'b101, 32'h0000DEAD, 1'b0);
      check_output("rd_count_5", 32'(rd_count), 32'd5);

      // Partial stores must preserve the untouched bytes
      run(1'b1, 9'h011, 32'h00000055, 3'b000, 32'h0, 1'b0);
      run(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0);
      run(1'b1, 9'h012, 32'h00001234, 3'b001, 32'h0, 1'b0);
      run(1'b0, 9'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0);
      check_output("wr_count_3", 32'(wr_count), 32'd3);
      check_output("rd_count_7", 32'(rd_count), 32'd7);

      // Misaligned and illegal encodings
      run(1'b0, 9'h012, 32'h0, 3'b010, 32'h0, 1'b1);
      run(1'b1, 9'h011, 32'hFFFFFFFF, 3'b001, 32'h0, 1'b1);
      run(1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1);
      run(1'b1, 9'h010, 32'hFFFFFFFF, 3'b110, 32'h0, 1'b1);
      run(1'b0, 9'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0);
      check_output("err_count_4", 32'(err_count), 32'd4);
      check_output("wr_count_err", 32'(wr_count), 32'd3);
      check_output("rd_count_8", 32'(rd_count), 32'd8);

      // Back-pressure: response held, a competing request must be ignored
      bus.rsp_ready = 1'b0;
      apply_stimulus(1'b0, 9'h010, 32'h0, 3'b010, 32'h123455EF, 1'b0);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_output("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check_output("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
         check_output("hold_busy", {31'b0, busy}, 32'd1);
         bus.req_we     = 1'b0;
         bus.req_addr   = 9'h014;
         bus.req_funct3 = 3'b010;
         bus.req_valid  = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("release_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check_output("release_busy", {31'b0, busy}, 32'd0);
      check_output("release_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check_output("rd_count_9", 32'(rd_count), 32'd9);

      // Asynchronous reset while a store is still in ACCESS
      apply_stimulus(1'b1, 9'h020, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0);
      #3 reset = 1'b0;
      #1;
      check_output("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
      check_output("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      check_output("midrst_busy", {31'b0, busy}, 32'd0);
      check_output("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_output("midrst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
      check_output("midrst_rd_count", 32'(rd_count), 32'd0);
      check_output("midrst_wr_count", 32'(wr_count), 32'd0);
      check_output("midrst_err_count", 32'(err_count), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run(1'b1, 9'h024, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
      run(1'b0, 9'h024, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
      run(1'b0, 9'h026, 32'h0, 3'b001, 32'hFFFFCAFE, 1'b0);
      check_output("post_wr_count", 32'(wr_count), 32'd1);
      check_output("post_rd_count", 32'(rd_count), 32'd2);
      check_output("post_err_count", 32'(err_count), 32'd0);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL leftover: got %0d responses pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
